// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: operation encoding and status-flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_SHL   = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_XOR   = 3'b101,
    ALU_SHR   = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic n;
  } alu_flags_t;

endpackage

// File: rtl/addsub_n.sv
// N-bit adder/subtractor: sub selects a + ~b + 1; reports carry-out and signed overflow.
module addsub_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   total;

  always_comb begin
    b_eff = sub ? ~b : b;
    total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    sum   = total[WIDTH-1:0];
    cout  = total[WIDTH];
    // Overflow when both addends share a sign that the result does not.
    ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered eight-op ALU with valid/ready handshake, status flags and chaining accumulator.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic [WIDTH-1:0] acc
);

  localparam logic [WIDTH:0] W_VAL = (WIDTH+1)'(WIDTH);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic             shift_zero;
  logic             shift_big;
  logic [WIDTH-1:0] res_f;
  alu_flags_t       res_flags;
  alu_flags_t       flags_q;
  logic             accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign op_a     = use_acc ? acc : a;

  addsub_n #(.WIDTH(WIDTH)) u_addsub (
    .a    (op_a),
    .b    (b),
    .sub  (op == ALU_SUB),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always_comb begin
    // Extra bit beyond the datapath catches the last bit shifted out.
    shl_ext    = {1'b0, op_a} << b;
    shr_ext    = {op_a, 1'b0} >> b;
    shift_zero = (b == '0);
    shift_big  = ({1'b0, b} >= W_VAL);
    res_f      = '0;
    res_flags  = '0;
    unique case (op)
      ALU_ADD, ALU_SUB: begin
        res_f       = sum;
        res_flags.c = cout;
        res_flags.v = ovf;
      end
      ALU_SHL: begin
        if (shift_zero)     res_f = op_a;
        else if (!shift_big) {res_flags.c, res_f} = shl_ext;
      end
      ALU_SHR: begin
        if (shift_zero)     res_f = op_a;
        else if (!shift_big) {res_f, res_flags.c} = shr_ext;
      end
      ALU_AND:   res_f = op_a & b;
      ALU_OR:    res_f = op_a | b;
      ALU_XOR:   res_f = op_a ^ b;
      ALU_PASSB: res_f = b;
      default:   res_f = '0;
    endcase
    res_flags.z = (res_f == '0);
    res_flags.n = res_f[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      f         <= '0;
      flags_q   <= '0;
      acc       <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        f         <= res_f;
        flags_q   <= res_flags;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Clear wins over a same-cycle result; that op already used the old acc.
      if (acc_clr)     acc <= '0;
      else if (accept) acc <= res_f;
    end
  end

  assign flag_z = flags_q.z;
  assign flag_c = flags_q.c;
  assign flag_v = flags_q.v;
  assign flag_n = flags_q.n;

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the team's 4-bit add/sub/shift/AND ALU. It adds an N-bit datapath, an eight-op set and a status-flag output. A valid/ready handshake on both sides lets it sit between an operand-issue stage and a result consumer with backpressure. An internal accumulator can replace operand A, so it can chain operations without external feedback.

## Interface
- WIDTH, 8, datapath width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept this cycle
- op  in  3  operation code (alu_pkg::alu_op_e)
- a  in  WIDTH  operand A (unsigned/two's-complement)
- b  in  WIDTH  operand B; shift amount for shifts
- use_acc  in  1  use accumulator instead of a
- acc_clr  in  1  clear accumulator at next edge
- out_valid  out  1  result held in output register
- out_ready  in  1  consumer takes result
- f  out  WIDTH  result
- flag_z, flag_c, flag_v, flag_n  out  1 each  zero, carry, signed overflow, negative
- acc  out  WIDTH  current accumulator value

## Operation
- Ops: 000 ADD a+b; 001 SUB a−b (a+~b+1); 010 SHL a<<b; 011 AND; 100 OR; 101 XOR; 110 SHR logical a>>b; 111 PASSB f=b.
- Effective A = use_acc ? acc : a.
- ADD/SUB: C = carry-out of the WIDTH-bit add. For SUB, C=1 means no borrow. V = signed overflow.
- Shifts: b treated unsigned.
  - 1 ≤ b ≤ WIDTH−1: C = last bit shifted out.
  - b = 0: f = A, C = 0.
  - b ≥ WIDTH: f = 0, C = 0.
- Shifts and logic ops: V = 0. Logic ops and PASSB: C = 0.
- Z = (f == 0). N = f[WIDTH−1]. All flags are registered together with f.
- Accept = in_valid & in_ready. On accept, f/flags load the new result and acc loads the same result.
- acc_clr forces acc to 0 at the edge and wins over an accepted result. An op accepted in that cycle still uses the pre-clear acc as operand.
- Reset (asynchronous, immediate): out_valid=0, f=0, all flags=0, acc=0. in_ready is 1 while out_valid=0.

## Timing
- Latency 1: an accept at edge k gives out_valid=1 with the result after edge k.
- in_ready = !out_valid | out_ready (combinational). Full throughput is one result per cycle when out_ready is held high.
- out_valid & !out_ready: f, flags and out_valid hold stable, and in_ready=0.
- Pop without a new accept clears out_valid next edge. Simultaneous pop and accept keep out_valid=1 with the new data.
- in_valid may be deasserted at any time. Inputs are sampled only at accept.
- rst_n low mid-transaction discards the held result. No output may glitch to valid during reset.
- use_acc back-to-back: the second op sees acc already updated by the first (no hazard bubble).

## Structure
- alu_pkg: alu_op_e enum (ALU_ADD…ALU_PASSB), flag struct alu_flags_t {z,c,v,n}.
- Sub-module addsub_n #(WIDTH): a, b, sub → sum, cout, ovf. It generalises the existing four-bit add/sub unit and is reused for ADD/SUB.
- Shifter, logic ops and result mux are combinational in alu_pipe. Output register, flag register and acc are sequential there.

## Test plan
- WIDTH=8, ADD 0xFF+0x01 → f=0x00, z=1 c=1 v=0 n=0, one cycle after accept. SUB 0x80−0x01 → f=0x7F, c=1 v=1 n=0.
- SHL a=0x81 b=1 → f=0x02 c=1. SHR a=0x81 b=1 → 0x40 c=1. SHL b=8 → f=0x00 c=0 z=1. SHL b=0 → f=0x81 c=0.
- Backpressure: hold out_ready=0 for 3 cycles with a second op pending → in_ready=0, f stable. Then raise out_ready → both results emerge in order, no loss or duplicate.
- Accumulate: acc_clr, then ADD use_acc b=0x05 three times back-to-back → f=0x05, 0x0A, 0x0F, acc=0x0F. acc_clr plus accepted ADD use_acc b=1 → f=0x10, acc=0x00.
- Throughput: 16 random ops with out_ready=1 → one result per cycle, all matching the reference model.
- Reset: drop rst_n while out_valid=1, acc≠0 → out_valid, f, flags and acc go to 0 without a clock edge, in_ready=1 after release.
